hetic_irq_taker: RTL and testbench

//  Core-side end of the HETIC interrupt handshake. Consumes the controller's

---
 rtl/hetic_pkg.sv | 31 +++
 rtl/hetic_irq_taker_if.sv | 23 ++
 rtl/irq_level_stack.sv | 52 +++++
 rtl/hetic_irq_taker.sv | 98 +++++++++
 tb/tb_hetic_irq_taker.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/hetic_pkg.sv
// Shared types and widths for the HETIC core-side interrupt taker.
package hetic_pkg;

  localparam int unsigned NrIrqLines = 64;
  localparam int unsigned NrIrqPrios = 32;
  localparam int unsigned StackDepth = 4;
  localparam int unsigned IrqWidth   = $clog2(NrIrqLines);
  localparam int unsigned PrioWidth  = $clog2(NrIrqPrios);
  localparam int unsigned DepthWidth = $clog2(StackDepth + 1);
  localparam int unsigned IdxWidth   = $clog2(StackDepth);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPend = 2'd1,
    StAck  = 2'd2
  } taker_state_e;

  typedef struct packed {
    logic                 nest;
    logic [PrioWidth-1:0] level;
  } irq_ctx_t;

  // Request snapshot held while a take is offered to the core.
  typedef struct packed {
    logic [IrqWidth-1:0]  id;
    logic [PrioWidth-1:0] level;
    logic                 heti;
    logic                 nest;
  } irq_latch_t;

endpackage

// File: rtl/hetic_irq_taker_if.sv
// Controller <-> taker handshake: arbitrated request in, claim pulse out.
interface hetic_irq_taker_if;
  import hetic_pkg::*;

  logic                 valid;
  logic [IrqWidth-1:0]  id;
  logic [PrioWidth-1:0] level;
  logic                 heti;
  logic                 nest;
  logic                 ack;
  logic [IrqWidth-1:0]  ack_id;

  modport master (
    output valid, id, level, heti, nest,
    input  ack, ack_id
  );

  modport slave (
    input  valid, id, level, heti, nest,
    output ack, ack_id
  );

endinterface

// File: rtl/irq_level_stack.sv
// LIFO of nested handler contexts; push+pop together replaces the top entry.
module irq_level_stack
  import hetic_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  irq_ctx_t              push_entry_i,
  output irq_ctx_t              top_o,
  output logic [DepthWidth-1:0] depth_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  underflow_o
);

  irq_ctx_t [StackDepth-1:0] mem_q, mem_d;
  logic [DepthWidth-1:0]     depth_q, depth_d;
  logic [IdxWidth-1:0]       top_idx, wr_idx;

  assign empty_o     = (depth_q == '0);
  assign full_o      = (depth_q == DepthWidth'(StackDepth));
  assign top_idx     = IdxWidth'(depth_q - DepthWidth'(1));
  assign wr_idx      = IdxWidth'(depth_q);
  assign top_o       = empty_o ? '0 : mem_q[top_idx];
  assign depth_o     = depth_q;
  assign underflow_o = pop_i & empty_o;

  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    if (push_i && pop_i && !empty_o) begin
      mem_d[top_idx] = push_entry_i;
    end else if (push_i && !full_o) begin
      mem_d[wr_idx] = push_entry_i;
      depth_d       = depth_q + DepthWidth'(1);
    end else if (pop_i && !empty_o) begin
      depth_d = depth_q - DepthWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '0;
      depth_q <= '0;
    end else begin
      mem_q   <= mem_d;
      depth_q <= depth_d;
    end
  end

endmodule

// File: rtl/hetic_irq_taker.sv
// Core-side end of the HETIC handshake: decides preemption, offers the take
// to the core, acks the controller and tracks nested handler levels.
module hetic_irq_taker
  import hetic_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  hetic_irq_taker_if.slave      irq_bus,
  input  logic                  mie_i,
  output logic                  take_req_o,
  output logic [IrqWidth-1:0]   take_id_o,
  output logic                  take_heti_o,
  input  logic                  take_ready_i,
  input  logic                  mret_i,
  output logic [PrioWidth-1:0]  cur_level_o,
  output logic [DepthWidth-1:0] depth_o,
  output logic                  underflow_o
);

  taker_state_e state_q, state_d;
  irq_latch_t   lat_q, lat_d;
  logic         underflow_q;

  irq_ctx_t top;
  logic     stack_push, stack_full, stack_empty, stack_underflow;
  logic     top_nest, eligible;

  irq_level_stack u_stack (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (stack_push),
    .pop_i        (mret_i),
    .push_entry_i ('{nest: lat_q.nest, level: lat_q.level}),
    .top_o        (top),
    .depth_o      (depth_o),
    .full_o       (stack_full),
    .empty_o      (stack_empty),
    .underflow_o  (stack_underflow)
  );

  assign cur_level_o = stack_empty ? '0 : top.level;
  assign top_nest    = stack_empty ? 1'b1 : top.nest;
  assign eligible    = irq_bus.valid & mie_i & (irq_bus.level > cur_level_o) & top_nest
                     & ~stack_full;

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    stack_push = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (eligible) begin
          lat_d   = '{id: irq_bus.id, level: irq_bus.level, heti: irq_bus.heti,
                      nest: irq_bus.nest};
          state_d = StPend;
        end
      end
      StPend: begin
        // A returning handler reshapes the stack, so re-arbitrate from idle.
        if (mret_i) begin
          state_d = StIdle;
        end else if (take_ready_i) begin
          state_d = StAck;
        end else if (!eligible) begin
          state_d = StIdle;
        end else if (irq_bus.level > lat_q.level) begin
          lat_d = '{id: irq_bus.id, level: irq_bus.level, heti: irq_bus.heti,
                    nest: irq_bus.nest};
        end
      end
      StAck: begin
        stack_push = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      lat_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      underflow_q <= underflow_q | stack_underflow;
    end
  end

  assign take_req_o     = (state_q == StPend);
  assign take_id_o      = lat_q.id;
  assign take_heti_o    = lat_q.heti;
  assign irq_bus.ack    = (state_q == StAck);
  assign irq_bus.ack_id = (state_q == StAck) ? lat_q.id : '0;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_hetic_irq_taker.sv
// Directed table-driven bench for hetic_irq_taker plus hand-written corner sequences.
module tb_hetic_irq_taker;
  import hetic_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  mie, take_req, take_heti, take_ready, mret, underflow;
  logic [IrqWidth-1:0]   take_id;
  logic [PrioWidth-1:0]  cur_level;
  logic [DepthWidth-1:0] depth;

  int n_cmp = 0;
  int n_err = 0;

  hetic_irq_taker_if bus ();

  hetic_irq_taker dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .irq_bus      (bus),
    .mie_i        (mie),
    .take_req_o   (take_req),
    .take_id_o    (take_id),
    .take_heti_o  (take_heti),
    .take_ready_i (take_ready),
    .mret_i       (mret),
    .cur_level_o  (cur_level),
    .depth_o      (depth),
    .underflow_o  (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [5:0] id;
    logic [4:0] lvl;
    logic       h, n, mie, rdy, mret;
    logic       e_treq;
    logic [5:0] e_tid;
    logic       e_thet, e_ack;
    logic [5:0] e_aid;
    logic [4:0] e_cur;
    logic [2:0] e_dep;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input int id, input int lvl, input logic h, input logic n,
                     input logic m, input logic rdy, input logic mr, input logic treq,
                     input int tid, input logic thet, input logic ack, input int aid,
                     input int cur, input int dep);
    vec_t t;
    t.v = v; t.id = 6'(id); t.lvl = 5'(lvl); t.h = h; t.n = n; t.mie = m; t.rdy = rdy;
    t.mret = mr; t.e_treq = treq; t.e_tid = 6'(tid); t.e_thet = thet; t.e_ack = ack;
    t.e_aid = 6'(aid); t.e_cur = 5'(cur); t.e_dep = 3'(dep);
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int id, input int lvl, input logic n,
                       input logic rdy, input logic mr);
    bus.valid = v; bus.id = 6'(id); bus.level = 5'(lvl); bus.heti = 1'b0; bus.nest = n;
    take_ready = rdy; mret = mr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.valid = 0; bus.id = '0; bus.level = '0; bus.heti = 0; bus.nest = 0;
    mie = 0; take_ready = 0; mret = 0;

    #2;
    check("rst_take_req", int'(take_req), 0);
    check("rst_ack", int'(bus.ack), 0);
    check("rst_depth", int'(depth), 0);
    check("rst_cur_level", int'(cur_level), 0);
    check("rst_underflow", int'(underflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    //  v  id lvl h n mie rdy mret | treq tid thet ack aid cur dep
    add(1, 7, 5, 0, 1, 1, 0, 0,   1, 7, 0, 0, 0, 0, 0);  // s1: lvl5 id7
    add(1, 7, 5, 0, 1, 1, 0, 0,   1, 7, 0, 0, 0, 0, 0);
    add(1, 7, 5, 0, 1, 1, 1, 0,   0, 0, 0, 1, 7, 0, 0);
    add(0, 7, 5, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 5, 1);
    add(1, 3, 9, 0, 1, 1, 0, 0,   1, 3, 0, 0, 0, 5, 1);  // s2: preempt
    add(1, 3, 9, 0, 1, 1, 1, 0,   0, 0, 0, 1, 3, 5, 1);
    add(0, 3, 9, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 9, 2);
    add(0, 3, 9, 0, 1, 1, 0, 1,   0, 0, 0, 0, 0, 5, 1);
    add(0, 3, 9, 0, 1, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    add(1, 4, 5, 0, 0, 1, 0, 0,   1, 4, 0, 0, 0, 0, 0);  // s3: non-nesting lvl5
    add(1, 4, 5, 0, 0, 1, 1, 0,   0, 0, 0, 1, 4, 0, 0);
    add(0, 4, 5, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 5, 1);
    add(1, 3, 9, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 5, 1);
    add(1, 3, 9, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 5, 1);
    add(1, 3, 9, 0, 1, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    add(1, 3, 9, 0, 1, 1, 0, 0,   1, 3, 0, 0, 0, 0, 0);
    add(1, 3, 9, 0, 1, 1, 1, 0,   0, 0, 0, 1, 3, 0, 0);
    add(0, 3, 9, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 9, 1);
    add(0, 3, 9, 0, 1, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    add(1, 7, 5, 0, 1, 1, 0, 0,   1, 7, 0, 0, 0, 0, 0);  // s4: re-latch higher
    add(1, 2, 8, 1, 1, 1, 0, 0,   1, 2, 1, 0, 0, 0, 0);
    add(1, 2, 8, 1, 1, 1, 1, 0,   0, 0, 0, 1, 2, 0, 0);
    add(0, 2, 8, 1, 1, 1, 0, 0,   0, 0, 0, 0, 0, 8, 1);
    add(0, 2, 8, 0, 1, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0);
    add(1, 6, 4, 0, 1, 1, 0, 0,   1, 6, 0, 0, 0, 0, 0);  // s5: mie drop withdraws
    add(1, 6, 4, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    add(1, 6, 4, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    add(1, 6, 4, 0, 1, 1, 0, 0,   1, 6, 0, 0, 0, 0, 0);
    add(0, 6, 4, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    add(1, 5, 3, 0, 1, 1, 0, 0,   1, 5, 0, 0, 0, 0, 0);  // mret beats ready in PEND
    add(1, 5, 3, 0, 1, 1, 1, 0,   0, 0, 0, 1, 5, 0, 0);
    add(1, 9, 7, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 3, 1);
    add(1, 9, 7, 0, 1, 1, 0, 0,   1, 9, 0, 0, 0, 3, 1);
    add(1, 9, 7, 0, 1, 1, 1, 1,   0, 0, 0, 0, 0, 0, 0);
    add(0, 9, 7, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      bus.valid = vecs[i].v; bus.id = vecs[i].id; bus.level = vecs[i].lvl;
      bus.heti = vecs[i].h; bus.nest = vecs[i].n; mie = vecs[i].mie;
      take_ready = vecs[i].rdy; mret = vecs[i].mret;
      step();
      check($sformatf("v%0d_take_req", i), int'(take_req), int'(vecs[i].e_treq));
      if (vecs[i].e_treq) begin
        check($sformatf("v%0d_take_id", i), int'(take_id), int'(vecs[i].e_tid));
        check($sformatf("v%0d_take_heti", i), int'(take_heti), int'(vecs[i].e_thet));
      end
      check($sformatf("v%0d_ack", i), int'(bus.ack), int'(vecs[i].e_ack));
      check($sformatf("v%0d_ack_id", i), int'(bus.ack_id), int'(vecs[i].e_aid));
      check($sformatf("v%0d_cur_level", i), int'(cur_level), int'(vecs[i].e_cur));
      check($sformatf("v%0d_depth", i), int'(depth), int'(vecs[i].e_dep));
      check($sformatf("v%0d_underflow", i), int'(underflow), 0);
    end

    // s6: fill the stack with levels 1..4, then a lvl31 request must not be offered
    mie = 1;
    for (int k = 0; k < 4; k++) begin
      drive(1, 10 + k, k + 1, 1, 0, 0);
      step();
      check($sformatf("fill%0d_take_req", k), int'(take_req), 1);
      take_ready = 1;
      step();
      check($sformatf("fill%0d_ack_id", k), int'(bus.ack_id), 10 + k);
      drive(0, 0, 0, 1, 0, 0);
      step();
      check($sformatf("fill%0d_depth", k), int'(depth), k + 1);
      check($sformatf("fill%0d_cur_level", k), int'(cur_level), k + 1);
    end
    drive(1, 20, 31, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("full%0d_no_take", k), int'(take_req), 0);
    end
    drive(0, 0, 0, 1, 0, 1);
    for (int k = 3; k >= 0; k--) begin
      step();
      check($sformatf("pop_depth%0d", k), int'(depth), k);
      check($sformatf("pop_uf%0d", k), int'(underflow), 0);
    end
    step();
    check("empty_mret_underflow", int'(underflow), 1);
    check("empty_mret_depth", int'(depth), 0);
    mret = 0;
    step();
    check("underflow_sticky", int'(underflow), 1);

    // Reset in the middle of a pending take
    drive(1, 5, 5, 1, 0, 0);
    step();
    check("mid_pend_take_req", int'(take_req), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_take_req", int'(take_req), 0);
    check("midrst_take_id", int'(take_id), 0);
    check("midrst_ack", int'(bus.ack), 0);
    check("midrst_depth", int'(depth), 0);
    check("midrst_cur_level", int'(cur_level), 0);
    check("midrst_underflow", int'(underflow), 0);
    step();
    check("held_rst_no_ack", int'(bus.ack), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
